// File: rtl/fir2x_unpack.sv
// ---------------------------------------------------------------------------
// fir2x_unpack
//
// Output stage of the 2x-unrolled 16-tap FIR. Each cycle the filter's output
// pair (y2k, y2k1) is captured when a delayed copy of the input-side valid
// says it is real data. Pairs are buffered in a FIFO and serialised onto a
// single-sample valid/ready stream, even sample first. When the FIFO is full
// and no pop happens, an incoming pair is dropped whole and the sticky
// overflow flag is raised.
//
// Optional feature macro: FIR2X_UNPACK_ROUND_EN
//   defined   : m_data = (sample + 2^(SHIFT-1)) >>> SHIFT, round-half-up
//   undefined : m_data = raw stored sample (SHIFT unused)
//
// Parameters:
//   DATA_W  sample width
//   DEPTH   FIFO depth in pairs (power of two, >= 2)
//   LAT     cycles from in_valid to the matching y2k/y2k1 (>= 1)
//   SHIFT   rounding right-shift amount
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-low reset (0 = in reset)
//   in_valid  filter input pair valid this cycle
//   y2k       filter even output, signed
//   y2k1      filter odd output, signed
//   m_data    serial output sample, signed
//   m_valid   m_data valid
//   m_ready   consumer accepts
//   level     pairs stored, 0..DEPTH
//   overflow  sticky, a valid pair was dropped
//   clr_ovf   clears overflow
// ---------------------------------------------------------------------------
module fir2x_unpack #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LAT    = 1,
    parameter int SHIFT  = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          y2k,
    input  logic [DATA_W-1:0]          y2k1,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } phase_t;

    phase_t            phase;
    phase_t            phase_nxt;
    logic [LAT-1:0]    vdly;
    logic              pvalid;
    logic [DATA_W-1:0] mem_even [DEPTH];
    logic [DATA_W-1:0] mem_odd  [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              fire;
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] head;

    // Valid delay line: its last stage lines up with y2k/y2k1 from the filter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vdly <= '0;
        end else begin
            vdly[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                vdly[i] <= vdly[i-1];
            end
        end
    end

    assign pvalid  = vdly[LAT-1];
    assign m_valid = (level != '0);
    assign fire    = m_valid & m_ready;
    // A pair leaves the FIFO only once its odd sample has been accepted.
    assign pop     = fire & (phase == ODD);
    // A full FIFO still accepts a pair when the head is popping this cycle.
    assign push    = pvalid & ((level < LW'(DEPTH)) | pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= EVEN;
        end else begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase;
        head      = mem_even[rptr];
        case (phase)
            EVEN: begin
                if (fire) phase_nxt = ODD;
            end
            ODD: begin
                head = mem_odd[rptr];
                if (fire) phase_nxt = EVEN;
            end
            default: phase_nxt = EVEN;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Set wins over clear so a drop in the clearing cycle is never lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (pvalid && !push) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Storage needs no reset; empty entries are masked at the output.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_even[wptr] <= y2k;
            mem_odd[wptr]  <= y2k1;
        end
    end

`ifdef FIR2X_UNPACK_ROUND_EN
    localparam logic signed [DATA_W:0] RND = {{DATA_W{1'b0}}, 1'b1} << (SHIFT-1);

    logic signed [DATA_W:0]   rsum;
    logic signed [DATA_W-1:0] rounded;

    // One extra bit of headroom so the rounding bias can never wrap.
    always_comb begin
        rsum    = $signed({head[DATA_W-1], head}) + RND;
        rounded = DATA_W'(rsum >>> SHIFT);
        m_data  = m_valid ? rounded : '0;
    end
`else
    always_comb begin
        m_data = m_valid ? head : '0;
    end
`endif

endmodule

// File: doc/fir2x_unpack.md
# fir2x_unpack

Downstream stage of the 2x-unrolled 16-tap FIR (`fir2x`). Each clock it captures the filter's output pair (`y2k`, `y2k1`) tagged by a delayed copy of the input-side valid, buffers pairs in a FIFO, and serialises them onto a single-sample valid/ready stream, even sample first. It absorbs the 2:1 rate mismatch between the free-running filter and the one-sample-per-cycle consumer, and flags lost pairs when the buffer overruns.

## Interface
- `DATA_W`, 32, sample width of `y2k`, `y2k1`, `m_data`
- `DEPTH`, 16, FIFO depth in pairs; power of two, ≥2
- `LAT`, 1, cycles from `in_valid` (qualifying `x2k`/`x2k1` at the filter input) to the matching `y2k`/`y2k1`; ≥1
- `SHIFT`, 11, right-shift used only when `FIR2X_UNPACK_ROUND_EN` is defined
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset (0 = in reset)
- `in_valid`  in  1  filter input pair valid this cycle
- `y2k`  in  DATA_W  filter even output, signed
- `y2k1`  in  DATA_W  filter odd output, signed
- `m_data`  out  DATA_W  serial output sample, signed
- `m_valid`  out  1  `m_data` valid
- `m_ready`  in  1  consumer accepts
- `level`  out  $clog2(DEPTH+1)  pairs stored, 0..DEPTH
- `overflow`  out  1  sticky: a valid pair was dropped
- `clr_ovf`  in  1  clears `overflow`

## Operation
- Valid delay line: `LAT` flops shift `in_valid`; the last stage (`pvalid`) qualifies `y2k`/`y2k1` in the same cycle.
- Write: when `pvalid`=1, pair {`y2k1`,`y2k`} is pushed if `level`<DEPTH, or if `level`==DEPTH and a pop occurs that cycle. Otherwise the pair is dropped and `overflow` is set.
- Read phase FSM, two states:
  - EVEN: `m_data` = head `y2k`. On `m_valid`&`m_ready` go to ODD.
  - ODD: `m_data` = head `y2k1`. On `m_valid`&`m_ready` pop the head and go to EVEN.
- `m_valid` = (`level`≠0). `m_data` is combinational from the head entry and phase. It is held stable while `m_valid`=1 and `m_ready`=0.
- `level` updates as +1 on push only, −1 on pop only, and unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- `overflow`: set has priority over `clr_ovf` in the same cycle. Otherwise `clr_ovf` clears it.
- Pairs are never reordered or partially emitted. A dropped pair loses both samples.

## Timing
- Reset (`reset`=0 at an edge) clears the delay line, both pointers, `level`=0, phase=EVEN, `m_valid`=0, `overflow`=0, and `m_data`=0 (head-entry content is don't-care).
- Reset mid-operation discards all stored and in-flight pairs, including any half-emitted pair. `y2k`/`y2k1` are ignored while in reset.
- Push at edge N gives `m_valid`=1 and the even sample on `m_data` from cycle N+1 when the FIFO was empty. There is no bypass path.
- With `m_ready` held high, one pair drains every 2 cycles. Sustained `pvalid`=1 therefore fills the FIFO at a net +1 pair per 2 cycles.
- `level` and `overflow` are registered; they reflect the current cycle's push/pop at the next edge.

## Configuration
- `FIR2X_UNPACK_ROUND_EN` defined: `m_data` = (sample + 2^(SHIFT−1)) >>> SHIFT, arithmetic, sign-extended to DATA_W. This is round-half-up and rescales the filter DC gain of 1910 toward unity. The addition is done at DATA_W+1 bits so it cannot wrap.
- Not defined: `m_data` is the raw stored sample, and `SHIFT` is unused.

## Test plan
- Reset → after one edge with `reset`=0: `m_valid`=0, `level`=0, `overflow`=0, `m_data`=0. Holds while `reset` stays 0 even with `in_valid`=1.
- LAT=1; one pair with `in_valid`=1 at cycle 0, and `y2k`=100, `y2k1`=−7 at cycle 1 → `m_data`=100 then −7 on consecutive beats with `m_ready`=1. Then `m_valid`=0 and `level` returns to 0.
- Backpressure: `m_ready`=0 for 5 cycles with one pair stored → `m_data` stays at the even value and `m_valid`=1. Release → odd value, then pop.
- Overflow: `m_ready`=0 with `pvalid`=1 for DEPTH+1 cycles → `level`=16 and `overflow`=1. The 17th pair is absent from the output. Pulsing `clr_ovf` clears the flag.
- Full with simultaneous pop (odd beat accepted) and `pvalid`=1 → pair accepted, `level` stays 16, `overflow` stays 0.
- `FIR2X_UNPACK_ROUND_EN`, SHIFT=11: `y2k`=1910·100=191000 → 93 (191000+1024=192024, >>11 = 93). `y2k1`=−1024 → 0 and −1025 → −1.
